// File: rtl/multicycle_control.sv
// Multicycle processor control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath strobes, counts retired instructions and traps on illegal opcodes
// or memory requests that go unacknowledged for too long.
module multicycle_control #(
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [5:0]       opcode,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             ir_write,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             alu_src_imm,
    output logic             read1_rd_select,
    output logic             wb_mem_select,
    output logic             reg_write,
    output logic             pc_write,
    output logic             pc_branch_select,
    output logic             retire,
    output logic [CNT_W-1:0] insn_count,
    output logic [2:0]       state,
    output logic             illegal_insn,
    output logic             bus_error
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StTrap   = 3'd7
    } state_t;

    // Class codes equal opcode[4:3] once opcode[5] is known to be zero.
    typedef enum logic [1:0] {
        ClsRrr = 2'd0,
        ClsRri = 2'd1,
        ClsJ   = 2'd2,
        ClsMem = 2'd3
    } cls_t;

    localparam int unsigned WaitW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'((WAIT_MAX == 0) ? 0 : WAIT_MAX - 1);

    state_t             r_state, r_state_d;
    cls_t               r_class, r_class_d;
    logic               r_is_sw, r_is_sw_d;
    logic [WaitW-1:0]   r_wait, r_wait_d;
    logic [CNT_W-1:0]   r_count, r_count_d;
    logic               r_illegal, r_illegal_d;
    logic               r_bus_err, r_bus_err_d;

    logic               w_timeout;
    state_t             w_after_retire;
    logic               w_unused_opcode;

    // The cycle that would make the wait count reach WAIT_MAX is the last allowed one.
    assign w_timeout       = (WAIT_MAX != 0) && (r_wait == WaitLast);
    assign w_after_retire  = run ? StFetch : StIdle;
    assign w_unused_opcode = ^opcode[2:1];

    assign state        = r_state;
    assign insn_count   = r_count;
    assign illegal_insn = r_illegal;
    assign bus_error    = r_bus_err;

    // State and bookkeeping registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_class   <= ClsRrr;
            r_is_sw   <= 1'b0;
            r_wait    <= '0;
            r_count   <= '0;
            r_illegal <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            r_state   <= r_state_d;
            r_class   <= r_class_d;
            r_is_sw   <= r_is_sw_d;
            r_wait    <= r_wait_d;
            r_count   <= r_count_d;
            r_illegal <= r_illegal_d;
            r_bus_err <= r_bus_err_d;
        end
    end

    // Next-state, strobe decode, wait counting and retire counting.
    always_comb begin
        imem_req         = 1'b0;
        ir_write         = 1'b0;
        dmem_req         = 1'b0;
        dmem_we          = 1'b0;
        alu_src_imm      = 1'b0;
        read1_rd_select  = 1'b0;
        wb_mem_select    = 1'b0;
        reg_write        = 1'b0;
        pc_write         = 1'b0;
        pc_branch_select = 1'b0;
        retire           = 1'b0;
        r_state_d        = r_state;
        r_class_d        = r_class;
        r_is_sw_d        = r_is_sw;
        r_wait_d         = '0;
        r_illegal_d      = r_illegal;
        r_bus_err_d      = r_bus_err;

        case (r_state)
            StIdle: begin
                if (run) r_state_d = StFetch;
            end
            StFetch: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_write  = 1'b1;
                    r_state_d = StDecode;
                end else if (w_timeout) begin
                    r_state_d   = StTrap;
                    r_bus_err_d = 1'b1;
                end else begin
                    r_wait_d = r_wait + WaitW'(1);
                end
            end
            StDecode: begin
                if (opcode[5]) begin
                    r_state_d   = StTrap;
                    r_illegal_d = 1'b1;
                end else begin
                    r_class_d = cls_t'(opcode[4:3]);
                    r_is_sw_d = opcode[0];
                    r_state_d = StExec;
                end
            end
            StExec: begin
                case (r_class)
                    ClsRrr: r_state_d = StWb;
                    ClsRri: begin
                        alu_src_imm = 1'b1;
                        r_state_d   = StWb;
                    end
                    ClsJ: begin
                        pc_write         = 1'b1;
                        pc_branch_select = 1'b1;
                        retire           = 1'b1;
                        r_state_d        = w_after_retire;
                    end
                    default: begin
                        read1_rd_select = r_is_sw;
                        r_state_d       = StMem;
                    end
                endcase
            end
            StMem: begin
                dmem_req        = 1'b1;
                dmem_we         = r_is_sw;
                read1_rd_select = r_is_sw;
                if (dmem_ack) begin
                    if (r_is_sw) begin
                        pc_write  = 1'b1;
                        retire    = 1'b1;
                        r_state_d = w_after_retire;
                    end else begin
                        r_state_d = StWb;
                    end
                end else if (w_timeout) begin
                    r_state_d   = StTrap;
                    r_bus_err_d = 1'b1;
                end else begin
                    r_wait_d = r_wait + WaitW'(1);
                end
            end
            StWb: begin
                reg_write     = 1'b1;
                wb_mem_select = (r_class == ClsMem);
                pc_write      = 1'b1;
                retire        = 1'b1;
                r_state_d     = w_after_retire;
            end
            StTrap: begin
                r_state_d = StTrap;
            end
            default: begin
                // Unused encoding: treat as a corrupted state.
                r_state_d   = StTrap;
                r_illegal_d = 1'b1;
            end
        endcase

        r_count_d = retire ? r_count + CNT_W'(1) : r_count;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter WAIT_MAX, default 15, max consecutive no-ack cycles per memory request before trap; 0 disables timeout.
REQ-002 Parameter CNT_W, default 32, width of retired-instruction counter.
REQ-003 Clocking is one clock and reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 run  input  1  permits starting a new instruction fetch.
REQ-007 opcode  input  6  instruction register bits [31:26], valid from DECODE onward.
REQ-008 imem_ack  input  1  instruction memory completion.
REQ-009 dmem_ack  input  1  data memory completion.
REQ-010 imem_req  output  1  instruction fetch request.
REQ-011 ir_write  output  1  load instruction register.
REQ-012 dmem_req  output  1  data memory request.
REQ-013 dmem_we  output  1  data memory write qualifier.
REQ-014 alu_src_imm  output  1  ALU operand 1 = zero-extended imm.
REQ-015 read1_rd_select  output  1  register read port 1 addressed by rd.
REQ-016 wb_mem_select  output  1  register write data from memory.
REQ-017 reg_write  output  1  register file write enable.
REQ-018 pc_write  output  1  PC update enable.
REQ-019 pc_branch_select  output  1  PC source = pc+1+sign-extended imm.
REQ-020 retire  output  1  one-cycle pulse per completed instruction.
REQ-021 insn_count  output  CNT_W  retired instruction count.
REQ-022 state  output  3  current state encoding.
REQ-023 illegal_insn  output  1  sticky illegal-opcode flag.
REQ-024 bus_error  output  1  sticky memory-timeout flag.

Function
REQ-025 States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=7; encoding 6 unused, SHALL go to TRAP with illegal_insn=1.
REQ-026 Class = opcode[5:3]: 000 ALU-RRR, 001 ALU-RRI, 010 J, 011 MEM (opcode[0]=0 LW, 1 SW); others illegal; class latched in DECODE.
REQ-027 IDLE -> FETCH when run=1; else hold.
REQ-028 FETCH: imem_req=1 every cycle until imem_ack sampled 1; that cycle ir_write=1 and next state DECODE.
REQ-029 DECODE: one cycle; illegal class -> TRAP with illegal_insn=1; else -> EXEC.
REQ-030 EXEC for ALU-RRR/RRI: alu_src_imm=1 only for RRI; -> WB.
REQ-031 EXEC for J: pc_write=1, pc_branch_select=1, retire=1; -> FETCH if run=1 else IDLE.
REQ-032 EXEC for LW/SW: read1_rd_select=1 for SW; -> MEM.
REQ-033 MEM: dmem_req=1, dmem_we=1 for SW only, read1_rd_select=1 for SW, held until dmem_ack sampled 1.
REQ-034 MEM ack for LW -> WB; ack for SW: pc_write=1, retire=1 same cycle, -> FETCH if run=1 else IDLE.
REQ-035 WB: reg_write=1, wb_mem_select=1 for LW only, pc_write=1, pc_branch_select=0, retire=1; -> FETCH if run=1 else IDLE.
REQ-036 Minimum latencies (ack same cycle as request): J 3, ALU 4, SW 4, LW 5 cycles.
REQ-037 Acks sampled only in FETCH (imem_ack) or MEM (dmem_ack); acks in other states ignored.
REQ-038 run deassertion never aborts an in-flight instruction; only gates IDLE/retire -> FETCH.
REQ-039 Wait counter clears on entering FETCH/MEM, increments per req-high no-ack cycle; reaching WAIT_MAX -> TRAP with bus_error=1, req drops next cycle.
REQ-040 Ack on the cycle counter would reach WAIT_MAX SHALL complete normally (ack wins).
REQ-041 TRAP: all strobes 0, flags held, exit only by rst.
REQ-042 insn_count increments by 1 per retire, wraps modulo 2^CNT_W.
REQ-043 All strobes are combinational from state and latched class; never asserted in IDLE/TRAP.

Reset
REQ-044 rst=1 at any cycle, including mid-request, SHALL next cycle give state=IDLE, all strobes 0, insn_count=0, illegal_insn=0, bus_error=0, wait counter 0.
REQ-045 rst overrides all transitions and acks in the same cycle.

Verification
REQ-046 run=1, acks tied 1, opcode 000000 -> states 1,2,3,5 repeat; retire every 4th cycle; insn_count=3 after 12 cycles.
REQ-047 LW (011000), dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, WB has reg_write=1 wb_mem_select=1.
REQ-048 SW (011001) ack immediate -> MEM asserts dmem_req=dmem_we=read1_rd_select=1, pc_write=retire=1 same cycle, no reg_write.
REQ-049 J (010000) -> EXEC pc_write=pc_branch_select=retire=1; 3-cycle instruction.
REQ-050 opcode 111000 -> TRAP, illegal_insn=1; imem_ack=0 with WAIT_MAX=15 -> TRAP after 15 cycles, bus_error=1; rst clears both.
REQ-051 rst pulsed during MEM wait -> IDLE next cycle, dmem_req=0, insn_count=0.
